// File: rtl/mc_ctrl_unit_if.sv
// mc_ctrl_unit_if
//   Control/status bundle between the multi-cycle MIPS controller and the
//   IR/ALU datapath plus the unified memory port.
//   Datapath -> controller : instr (IR contents), zero (ALU rs-rt == 0),
//                            mem_ready (memory completes request this cycle)
//   Memory port            : mem_req, mem_we, iord (0 PC, 1 ALUOut address)
//   IR / PC                : ir_we, pc_we, pc_src
//   ALU                    : alu_src_a, alu_src_b, alu_op
//   Immediate extender     : sign_ext
//   Register file          : reg_we, reg_dst, mem_to_reg
//   Status                 : illegal (sticky error), retired (instruction count)
interface mc_ctrl_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      instr;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             sign_ext;
    logic             reg_we;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr, zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src,
               alu_src_a, alu_src_b, alu_op, sign_ext,
               reg_we, reg_dst, mem_to_reg, illegal, retired
    );

    modport slave (
        output instr, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src,
               alu_src_a, alu_src_b, alu_op, sign_ext,
               reg_we, reg_dst, mem_to_reg, illegal, retired
    );
endinterface

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit
//   Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback over a
//   shared ALU, register file and memory port. Supports addu, subu, ori, lw,
//   sw, beq, j; anything else (or a memory request outstanding for
//   MEM_TIMEOUT cycles) parks the FSM in ERROR until reset.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mc_ctrl_unit_if.master (IR/zero/mem_ready in, all controls out)
module mc_ctrl_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input logic           clk,
    input logic           rst_n,
    mc_ctrl_unit_if.master bus
);
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [5:0]        opcode, funct;
    logic              wait_expired, retire;

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];

    // Limit cycle only errors if the memory has not answered in that same cycle.
    assign wait_expired = (wait_q == WAIT_LIMIT) && !bus.mem_ready;

    assign retire = (state_q == S_WB_R) || (state_q == S_WB_I) || (state_q == S_WB_MEM) ||
                    (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                    ((state_q == S_MEM_WR) && bus.mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready)     state_d = S_DECODE;
                else if (wait_expired) state_d = S_ERROR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = (funct == FN_ADDU || funct == FN_SUBU) ? S_EXEC_R : S_ERROR;
                    OP_ORI:       state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ERROR;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            // Only lw/sw reach here, so the opcode test needs just one bit of choice.
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (bus.mem_ready)     state_d = S_WB_MEM;
                else if (wait_expired) state_d = S_ERROR;
            end
            S_MEM_WR: begin
                if (bus.mem_ready)     state_d = S_FETCH;
                else if (wait_expired) state_d = S_ERROR;
            end
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase
    end

    // Any state change clears the counter, which covers entry into every
    // request state as well as the transition into ERROR.
    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) || bus.mem_ready) wait_d = '0;
        else if (bus.mem_req)                      wait_d = wait_q + WAIT_W'(1);
    end

    always_comb begin
        retired_d = retired_q;
        if (retire) retired_d = retired_q + CNT_W'(1);
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = 2'b00;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = ALU_ADD;
        bus.sign_ext   = 1'b0;
        bus.reg_we     = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_we     = bus.mem_ready;
                bus.pc_we     = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                bus.sign_ext  = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = ALU_OR;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.sign_ext  = 1'b1;
            end
            S_MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.iord    = 1'b1;
            end
            S_WB_R: begin
                bus.reg_we  = 1'b1;
                bus.reg_dst = 1'b1;
            end
            S_WB_I:   bus.reg_we = 1'b1;
            S_WB_MEM: begin
                bus.reg_we     = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_SUB;
                bus.pc_we     = bus.zero;
                bus.pc_src    = 2'b01;
            end
            S_JUMP: begin
                bus.pc_we  = 1'b1;
                bus.pc_src = 2'b10;
            end
            S_ERROR:  bus.illegal = 1'b1;
            default:  ;
        endcase
    end

    assign bus.retired = retired_q;
endmodule
